// File: rtl/booth_arbitro_secuenciador.sv
// Round-robin arbiter plus counter-driven sequencer for a shared radix-2 Booth datapath.
// One operation: LOAD, N x (EVAL, SHIFT), DONE; strobes decode from state.
module booth_arbitro_secuenciador #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic q0,
  input  logic qsub1,
  output logic sel,
  output logic busy,
  output logic CargaQ,
  output logic CargaM,
  output logic ResetA,
  output logic CargaA,
  output logic Resta,
  output logic DesplazaAQ,
  output logic done0,
  output logic done1
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             winner;

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    winner     = (req0 && req1) ? ~last_q : req1;
    CargaQ     = 1'b0;
    CargaM     = 1'b0;
    ResetA     = 1'b0;
    CargaA     = 1'b0;
    Resta      = 1'b0;
    DesplazaAQ = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d   = winner;
          last_d  = winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        CargaQ  = 1'b1;
        CargaM  = 1'b1;
        ResetA  = 1'b1;
        cnt_d   = CNT_W'(N);
        state_d = EVAL;
      end
      EVAL: begin
        // Booth pair 01 adds M, 10 subtracts M, 00/11 leave A alone.
        CargaA  = q0 ^ qsub1;
        Resta   = q0 & ~qsub1;
        state_d = SHIFT;
      end
      SHIFT: begin
        DesplazaAQ = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
        state_d    = (cnt_q == CNT_W'(1)) ? DONE : EVAL;
      end
      DONE: begin
        done0   = ~sel_q;
        done1   = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel  = sel_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_booth_arbitro_secuenciador.sv
// Bench for booth_arbitro_secuenciador: schedule-level reference model of grants and strobes,
// scenario tasks with inline checks, and a grant-order scoreboard.
module tb_booth_arbitro_secuenciador;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset, req0, req1, q0, qsub1;
  logic sel, busy, CargaQ, CargaM, ResetA, CargaA, Resta, DesplazaAQ, done0, done1;
  logic n2_req0, n2_req1, n2_q0, n2_qs;
  logic n2_sel, n2_busy, n2_cq, n2_cm, n2_ra, n2_ca, n2_rs, n2_dz, n2_d0, n2_d1;

  always #5 clk = ~clk;

  booth_arbitro_secuenciador #(.N(N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .q0(q0), .qsub1(qsub1),
    .sel(sel), .busy(busy), .CargaQ(CargaQ), .CargaM(CargaM), .ResetA(ResetA),
    .CargaA(CargaA), .Resta(Resta), .DesplazaAQ(DesplazaAQ), .done0(done0), .done1(done1)
  );

  booth_arbitro_secuenciador #(.N(2), .CNT_W(4)) dut_n2 (
    .clk(clk), .reset(reset), .req0(n2_req0), .req1(n2_req1), .q0(n2_q0), .qsub1(n2_qs),
    .sel(n2_sel), .busy(n2_busy), .CargaQ(n2_cq), .CargaM(n2_cm), .ResetA(n2_ra),
    .CargaA(n2_ca), .Resta(n2_rs), .DesplazaAQ(n2_dz), .done0(n2_d0), .done1(n2_d1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: an operation granted in idle cycle g occupies cycles g+1 .. g+2N+2.
  bit         m_active;
  int         m_g;
  logic       m_who, m_sel, m_last;
  logic [0:0] exp_q[$];
  logic [9:0] obs, exp_v;

  assign obs = {sel, busy, CargaQ, CargaM, ResetA, CargaA, Resta, DesplazaAQ, done0, done1};

  function automatic logic [9:0] expect_out(bit act, int p, int n, logic who, logic sel_idle,
                                            logic a, logic b);
    logic [9:0] v;
    v = '0;
    if (!act) begin
      v[9] = sel_idle;
      return v;
    end
    v[9] = who;
    v[8] = 1'b1;
    if (p == 1) v[7:5] = 3'b111;
    else if (p == 2*n + 2) begin
      v[1] = ~who;
      v[0] = who;
    end else if (p % 2 == 0) begin
      v[4] = a ^ b;
      v[3] = a & ~b;
    end else v[2] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_g      = 0;
    m_who    = 1'b0;
    m_sel    = 1'b0;
    m_last   = 1'b1;
    exp_q.delete();
  endtask

  // Advance the model past the current cycle, then the clock to the next negedge.
  task automatic step();
    logic winner;
    if (m_active) begin
      if (cyc - m_g == 2*N + 2) begin
        m_active = 0;
        m_sel    = m_who;
      end
    end else if (req0 || req1) begin
      winner   = (req0 && req1) ? ~m_last : req1;
      m_active = 1;
      m_g      = cyc;
      m_who    = winner;
      m_last   = winner;
      exp_q.push_back(winner);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", obs, 10'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_single();
    int c0, done_at;
    c0      = cyc;
    done_at = -1;
    req0    = 1'b1;
    for (int i = 0; i < 2*N + 4; i++) begin
      {q0, qsub1} = 2'($urandom_range(0, 3));
      if (m_active && cyc - m_g == 2*N + 2) req0 = 1'b0;
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
      if (done0 && done_at < 0) done_at = cyc - c0;
      step();
    end
    checks++;
    if (done_at != 2*N + 2) begin
      errors++;
      $display("FAIL single_latency got=%0d want=%0d", done_at, 2*N + 2);
    end
  endtask

  task automatic test_eval_table();
    int c0;
    c0   = cyc;
    req1 = 1'b1;
    for (int i = 0; i < 2*N + 4; i++) begin
      {q0, qsub1} = 2'((cyc - c0) >> 1);
      if (m_active && cyc - m_g == 2*N + 2) req1 = 1'b0;
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL eval_table cyc=%0d q=%b%b got=%b want=%b", cyc, q0, qsub1, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int   last_done, ndone;
    logic prev;
    exp_q.delete();
    last_done = -1;
    ndone     = 0;
    prev      = 1'b0;
    req0      = 1'b1;
    req1      = 1'b1;
    for (int i = 0; i < 4*(2*N + 3) + 2; i++) begin
      {q0, qsub1} = 2'($urandom_range(0, 3));
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
      if (done0 || done1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_order unexpected done got=%b%b want=none", done0, done1);
        end else begin
          if (exp_q[0] !== done1) begin
            errors++;
            $display("FAIL b2b_order got=%b want=%b", done1, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != 2*N + 3) begin
            errors++;
            $display("FAIL b2b_period got=%0d want=%0d", cyc - last_done, 2*N + 3);
          end
          checks++;
          if (done1 === prev) begin
            errors++;
            $display("FAIL b2b_alternate got=%b want=%b", done1, ~prev);
          end
        end
        last_done = cyc;
        prev      = done1;
        ndone++;
      end
      step();
    end
    checks++;
    if (ndone != 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=4", ndone);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 2*N + 4; i++) begin
      {q0, qsub1} = 2'($urandom_range(0, 3));
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b_drain cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_late_req();
    int r, seen;
    exp_q.delete();
    r    = $urandom_range(2, 2*N);
    seen = 0;
    req1 = 1'b1;
    req0 = 1'b0;
    for (int i = 0; i < 2*(2*N + 3) + 2; i++) begin
      if (i == r) req0 = 1'b1;
      if (m_active && cyc - m_g == 2*N + 2) begin
        if (m_who) req1 = 1'b0;
        else       req0 = 1'b0;
      end
      {q0, qsub1} = 2'($urandom_range(0, 3));
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL late_req cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
      if (done0 || done1) begin
        checks++;
        if (done1 !== (seen == 0)) begin
          errors++;
          $display("FAIL late_req_order done#%0d got=%b want=%b", seen, done1, seen == 0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen++;
      end
      step();
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL late_req_count got=%0d want=2", seen);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    bit first_seen;
    hit  = 0;
    req0 = 1'b1;
    req1 = 1'b0;
    for (int i = 0; i < 2*N + 4 && !hit; i++) begin
      {q0, qsub1} = 2'($urandom_range(0, 3));
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
      if (m_active && cyc - m_g == 7) begin
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 10'b0) begin
          errors++;
          $display("FAIL reset_mid_outputs got=%b want=%b", obs, 10'b0);
        end
        hit = 1;
      end else step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach got=0 want=1");
    end
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_hold got=%b want=%b", obs, 10'b0);
    end
    @(negedge clk);
    reset      = 1'b0;
    req0       = 1'b1;
    req1       = 1'b1;
    first_seen = 0;
    for (int i = 0; i < 2*N + 4; i++) begin
      if (m_active && cyc - m_g == 2*N + 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      {q0, qsub1} = 2'($urandom_range(0, 3));
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_post cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      end
      if ((done0 || done1) && !first_seen) begin
        checks++;
        if (done0 !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_grant got=done1 want=done0");
        end
        first_seen = 1;
      end
      step();
    end
  endtask

  task automatic test_random();
    exp_q.delete();
    for (int i = 0; i < 420; i++) begin
      if (i < 400) begin
        req0 = ($urandom_range(0, 3) != 0);
        req1 = ($urandom_range(0, 2) == 0);
      end else begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      {q0, qsub1} = 2'($urandom_range(0, 3));
      #1;
      exp_v = expect_out(m_active, cyc - m_g, N, m_who, m_sel, q0, qsub1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b%b got=%b want=%b", cyc, req0, req1, obs, exp_v);
      end
      if (done0 || done1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_order unexpected done got=%b%b want=none", done0, done1);
        end else begin
          if (exp_q[0] !== done1) begin
            errors++;
            $display("FAIL random_order got=%b want=%b", done1, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_n2();
    int shifts, done_at;
    shifts  = 0;
    done_at = -1;
    n2_req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0) begin
        checks++;
        if (n2_busy !== 1'b0) begin
          errors++;
          $display("FAIL n2_idle_busy got=%b want=0", n2_busy);
        end
      end
      if (n2_dz) shifts++;
      if (n2_d0 && done_at < 0) begin
        done_at = i;
        n2_req0 = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (shifts != 2) begin
      errors++;
      $display("FAIL n2_shifts got=%0d want=2", shifts);
    end
    checks++;
    if (done_at != 6) begin
      errors++;
      $display("FAIL n2_latency got=%0d want=6", done_at);
    end
  endtask

  initial begin
    reset   = 1'b1;
    req0    = 1'b0;
    req1    = 1'b0;
    q0      = 1'b0;
    qsub1   = 1'b0;
    n2_req0 = 1'b0;
    n2_req1 = 1'b0;
    n2_q0   = 1'b0;
    n2_qs   = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_eval_table();
    test_back_to_back();
    test_late_req();
    test_reset_mid();
    test_random();
    test_n2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_arbitro_secuenciador.md
Name: booth_arbitro_secuenciador

Overview:
Sequencer for the radix-2 Booth multiplier datapath. It also arbitrates that single datapath between two requesters.
- Grants one requester round-robin, drives the operand-select mux and emits the datapath strobes (CargaQ, CargaM, ResetA, CargaA, Resta, DesplazaAQ) for N iterations.
- Returns a one-cycle done pulse to the granted requester.
- Sits between the client blocks and the multiplier datapath, replacing a fixed-length sequencer with a counter-driven one.

Parameters:
- N, 8, operand width = number of Booth iterations (2..15)
- CNT_W, 4, width of the iteration counter (must hold N)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 level request; held until done0
- req1  in  1  requester 1 level request; held until done1
- q0  in  1  datapath Q[0]
- qsub1  in  1  datapath Q[-1] bit
- sel  out  1  operand/result mux select (0 = requester 0, 1 = requester 1)
- busy  out  1  operation in progress (any state except IDLE)
- CargaQ  out  1  load multiplier into Q, clear Q[-1]
- CargaM  out  1  load multiplicand into M
- ResetA  out  1  clear accumulator A
- CargaA  out  1  write A <= A ± M
- Resta  out  1  adder performs subtraction
- DesplazaAQ  out  1  arithmetic shift right of A:Q:Q[-1]
- done0  out  1  one-cycle completion pulse, requester 0
- done1  out  1  one-cycle completion pulse, requester 1

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, cnt=0, sel=0, last=1 (requester 0 wins first tie).
  - All outputs 0. The aborted operation produces no done pulse.
- States: IDLE, LOAD, EVAL, SHIFT, DONE. State, cnt, sel and last are registered; outputs are decoded from state, and only CargaA/Resta also depend on q0/qsub1.
- IDLE:
  - Only req0 → grant 0. Only req1 → grant 1.
  - Both → grant !last.
  - On grant: sel<=winner, last<=winner, next=LOAD. No req → stay.
- LOAD (1 cycle): CargaQ=CargaM=ResetA=1; cnt<=N; next=EVAL.
- EVAL (1 cycle):
  - CargaA = q0 XOR qsub1.
  - Resta = q0 AND NOT qsub1.
  - next=SHIFT.
- SHIFT (1 cycle): DesplazaAQ=1; cnt<=cnt-1; next = DONE if cnt==1, else EVAL.
- DONE (1 cycle):
  - done[sel]=1, other done=0.
  - next=IDLE; a new grant is possible on the following cycle, so there is one idle cycle between operations.
- Signal gating:
  - Resta and CargaA are 0 outside EVAL.
  - Only one of {LOAD group, CargaA, DesplazaAQ} is active in any cycle.
- sel is stable from LOAD through DONE and holds its value in IDLE.
- Latency: grant cycle in IDLE + 1 (LOAD) + 2N (EVAL/SHIFT) + 1 (DONE). done asserts 2N+2 cycles after the IDLE cycle that samples req.
- Boundary conditions:
  - Requests arriving or dropping while busy are ignored until IDLE; a dropped req does not abort the operation.
  - A req still high in IDLE right after its DONE is re-granted only if the other req is low (round-robin fairness).
  - cnt never underflows: DONE is entered with cnt=0.
- Illegal state encodings → IDLE.

Test Plan:
1. N=4; req0=1 at cycle 0 (IDLE, post-reset):
   - LOAD at cycle 1 with CargaQ/CargaM/ResetA=1 and sel=0.
   - EVAL at 2,4,6,8; SHIFT at 3,5,7,9.
   - done0=1 at cycle 10 only; busy=1 during cycles 1–10.
2. EVAL with (q0,qsub1) = 00/01/10/11:
   - CargaA = 0/1/1/0.
   - Resta = 0/0/1/0.
   - In SHIFT with (q0,qsub1)=10: CargaA=Resta=0 and DesplazaAQ=1.
3. req0 and req1 both held high continuously:
   - Grants alternate 0,1,0,1; sel follows.
   - done0/done1 alternate every 2N+3 cycles (19 for N=8).
4. req1 only, then req0 rises mid-operation:
   - Current op completes with done1 and no glitch on sel.
   - Next grant goes to 0.
5. Assert reset during the 3rd SHIFT:
   - Same cycle: all outputs 0, busy=0.
   - No done pulse.
   - After release with both req high, requester 0 is granted.
6. N=2 boundary: exactly 2 DesplazaAQ pulses, and done asserts 6 cycles after the IDLE cycle that samples req.
